// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A-class interrupt controller: OCW2 command codes
// and width-generic rotate/priority helpers (operate on up to 32 levels).
package pic_pkg;

  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  localparam int unsigned PIC_MAX_IRQ = 32;

  // Rotations act on the low n bits only; bits at or above n are returned as zero.
  function automatic logic [31:0] rotate_right(input logic [31:0] v, input int unsigned sh,
                                               input int unsigned n);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < PIC_MAX_IRQ; i++)
      if (i < n) r[5'(i)] = v[5'((i + sh) % n)];
    return r;
  endfunction

  function automatic logic [31:0] rotate_left(input logic [31:0] v, input int unsigned sh,
                                              input int unsigned n);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < PIC_MAX_IRQ; i++)
      if (i < n) r[5'((i + sh) % n)] = v[5'(i)];
    return r;
  endfunction

  function automatic logic [31:0] find_first(input logic [31:0] v);
    logic [31:0] r;
    logic        found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < PIC_MAX_IRQ; i++)
      if (v[5'(i)] && !found) begin
        r[5'(i)] = 1'b1;
        found    = 1'b1;
      end
    return r;
  endfunction

  function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
    logic [4:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < PIC_MAX_IRQ; i++)
      if (v[5'(i)] && !found) begin
        idx   = 5'(i);
        found = 1'b1;
      end
    return idx;
  endfunction

endpackage

// File: rtl/pic_rotating_priority.sv
// Combinational rotating-priority picker: level (pointer+1) mod NUM_IRQ is highest,
// pointer itself lowest. Shared by the ISR controller and the request resolver.
module pic_rotating_priority
  import pic_pkg::*;
#(
  parameter  int unsigned NUM_IRQ = 8,
  localparam int unsigned PTR_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] request,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_IRQ-1:0] highest
);

  logic [31:0] shift;

  assign shift   = (32'(pointer) + 32'd1) % 32'(NUM_IRQ);
  assign highest = NUM_IRQ'(rotate_left(find_first(rotate_right(32'(request), shift, NUM_IRQ)),
                                        shift, NUM_IRQ));

endmodule

// File: rtl/in_service_ctrl.sv
// In-service register controller: sets ISR bits on acknowledge, clears them on OCW2 EOI
// commands and owns the rotation pointer. Define IN_SERVICE_AEOI_EN for automatic EOI.
module in_service_ctrl
  import pic_pkg::*;
#(
  parameter  int unsigned NUM_IRQ = 8,
  localparam int unsigned PTR_W   = $clog2(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ack_valid,
  input  logic [NUM_IRQ-1:0] ack_vector,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_code,
  input  logic [PTR_W-1:0]   cmd_level,
`ifdef IN_SERVICE_AEOI_EN
  input  logic               auto_eoi,
`endif
  output logic [NUM_IRQ-1:0] in_service_register,
  output logic [NUM_IRQ-1:0] highest_isr,
  output logic [PTR_W-1:0]   priority_ptr,
  output logic               ack_error
);

  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               rot_aeoi_q, rot_aeoi_d;
  logic               err_q, err_d;

  logic [NUM_IRQ-1:0] clr_mask, post_clr, level_oh;
  logic [PTR_W-1:0]   highest_idx;
  logic               level_ok;

  pic_rotating_priority #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .request (isr_q),
    .pointer (ptr_q),
    .highest (highest_isr)
  );

  assign highest_idx = PTR_W'(onehot_to_idx(32'(highest_isr)));
  assign level_ok    = 32'(cmd_level) < NUM_IRQ;
  assign level_oh    = NUM_IRQ'(32'd1 << cmd_level);

  always_comb begin
    clr_mask   = '0;
    ptr_d      = ptr_q;
    rot_aeoi_d = rot_aeoi_q;
    if (cmd_valid && level_ok) begin
      case (cmd_code)
        OCW2_NS_EOI:       clr_mask = highest_isr;
        OCW2_SP_EOI:       clr_mask = level_oh;
        OCW2_ROT_NS_EOI:
          if (|highest_isr) begin
            clr_mask = highest_isr;
            ptr_d    = highest_idx;
          end
        OCW2_ROT_SP_EOI: begin
          clr_mask = level_oh;
          ptr_d    = cmd_level;
        end
        OCW2_SET_PRIO:     ptr_d      = cmd_level;
        OCW2_ROT_AEOI_SET: rot_aeoi_d = 1'b1;
        OCW2_ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
        default: ;
      endcase
    end

    // Clear uses the pre-cycle ISR; the acknowledge set is layered on top so it wins.
    post_clr = isr_q & ~clr_mask;
    isr_d    = post_clr;
    err_d    = err_q;
    if (ack_valid) begin
      if ((ack_vector == '0) || ((ack_vector & (ack_vector - NUM_IRQ'(1))) != '0) ||
          ((ack_vector & post_clr) != '0))
        err_d = 1'b1;
`ifdef IN_SERVICE_AEOI_EN
      if (auto_eoi) begin
        if (rot_aeoi_q) ptr_d = PTR_W'(onehot_to_idx(32'(ack_vector)));
      end else begin
        isr_d = post_clr | ack_vector;
      end
`else
      isr_d = post_clr | ack_vector;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      isr_q      <= '0;
      ptr_q      <= PTR_W'(NUM_IRQ - 1);
      rot_aeoi_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      isr_q      <= isr_d;
      ptr_q      <= ptr_d;
      rot_aeoi_q <= rot_aeoi_d;
      err_q      <= err_d;
    end
  end

  assign in_service_register = isr_q;
  assign priority_ptr        = ptr_q;
  assign ack_error           = err_q;

endmodule

// File: tb/tb_in_service_ctrl.sv
// Scoreboard bench for in_service_ctrl: an 8-level and a 5-level instance driven by
// directed vectors; expected state is queued per step and checked by a monitor.
module tb_in_service_ctrl;

  logic       clock;
  logic       reset;

  logic       a_av, a_cv;
  logic [7:0] a_vec;
  logic [2:0] a_code, a_lvl;
  logic [7:0] a_isr, a_hi;
  logic [2:0] a_ptr;
  logic       a_err;

  logic       b_av, b_cv;
  logic [4:0] b_vec;
  logic [2:0] b_code, b_lvl;
  logic [4:0] b_isr, b_hi;
  logic [2:0] b_ptr;
  logic       b_err;

`ifdef IN_SERVICE_AEOI_EN
  logic       a_aeoi, b_aeoi;
`endif

  typedef struct {
    int         d;
    logic [7:0] isr;
    logic [7:0] hi;
    logic [2:0] ptr;
    logic       err;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  in_service_ctrl #(.NUM_IRQ(8)) dut8 (
    .clock(clock), .reset(reset),
    .ack_valid(a_av), .ack_vector(a_vec),
    .cmd_valid(a_cv), .cmd_code(a_code), .cmd_level(a_lvl),
`ifdef IN_SERVICE_AEOI_EN
    .auto_eoi(a_aeoi),
`endif
    .in_service_register(a_isr), .highest_isr(a_hi),
    .priority_ptr(a_ptr), .ack_error(a_err)
  );

  in_service_ctrl #(.NUM_IRQ(5)) dut5 (
    .clock(clock), .reset(reset),
    .ack_valid(b_av), .ack_vector(b_vec),
    .cmd_valid(b_cv), .cmd_code(b_code), .cmd_level(b_lvl),
`ifdef IN_SERVICE_AEOI_EN
    .auto_eoi(b_aeoi),
`endif
    .in_service_register(b_isr), .highest_isr(b_hi),
    .priority_ptr(b_ptr), .ack_error(b_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input string f, input int d, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d %s: got %h want %h", nm, d, f, got, want);
    end
  endtask

  // Monitor: state is stable at the falling edge; drain every queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.d == 0) begin
          chk(e.nm, "isr", 0, a_isr, e.isr);
          chk(e.nm, "highest", 0, a_hi, e.hi);
          chk(e.nm, "ptr", 0, {5'b0, a_ptr}, {5'b0, e.ptr});
          chk(e.nm, "ack_error", 0, {7'b0, a_err}, {7'b0, e.err});
        end else begin
          chk(e.nm, "isr", 1, {3'b0, b_isr}, e.isr);
          chk(e.nm, "highest", 1, {3'b0, b_hi}, e.hi);
          chk(e.nm, "ptr", 1, {5'b0, b_ptr}, {5'b0, e.ptr});
          chk(e.nm, "ack_error", 1, {7'b0, b_err}, {7'b0, e.err});
        end
      end
    end
  end

  task automatic step(input logic rst, input int d, input logic av, input logic [7:0] vec,
                      input logic cv, input logic [2:0] code, input logic [2:0] lvl,
                      input logic [7:0] e_isr, input logic [7:0] e_hi,
                      input logic [2:0] e_ptr, input logic e_err, input string nm);
    reset = rst;
    if (d == 0) begin
      a_av = av; a_vec = vec; a_cv = cv; a_code = code; a_lvl = lvl;
    end else begin
      b_av = av; b_vec = vec[4:0]; b_cv = cv; b_code = code; b_lvl = lvl;
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    a_av = 1'b0; a_vec = '0; a_cv = 1'b0; a_code = '0; a_lvl = '0;
    b_av = 1'b0; b_vec = '0; b_cv = 1'b0; b_code = '0; b_lvl = '0;
    q.push_back('{d, e_isr, e_hi, e_ptr, e_err, nm});
  endtask

  initial begin
    reset = 1'b1;
    a_av = 1'b0; a_vec = '0; a_cv = 1'b0; a_code = '0; a_lvl = '0;
    b_av = 1'b0; b_vec = '0; b_cv = 1'b0; b_code = '0; b_lvl = '0;
`ifdef IN_SERVICE_AEOI_EN
    a_aeoi = 1'b0; b_aeoi = 1'b0;
`endif
    //   rst d  av vec    cv code    lvl    isr    hi     ptr e
    step(1, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h00, 7, 0, "reset8");
    q.push_back('{1, 8'h00, 8'h00, 3'd4, 1'b0, "reset5"});

    step(0, 0, 1, 8'h04, 0, 3'b000, 3'd0, 8'h04, 8'h04, 7, 0, "t1_ack04");
    step(0, 0, 1, 8'h01, 0, 3'b000, 3'd0, 8'h05, 8'h01, 7, 0, "t1_ack01");
    step(0, 0, 0, 8'h00, 1, 3'b001, 3'd0, 8'h04, 8'h04, 7, 0, "t1_nseoi");

    step(0, 0, 1, 8'h01, 0, 3'b000, 3'd0, 8'h05, 8'h01, 7, 0, "t2_ack01");
    step(0, 0, 0, 8'h00, 1, 3'b101, 3'd0, 8'h04, 8'h04, 0, 0, "t2_rotns");
    step(0, 0, 1, 8'h01, 0, 3'b000, 3'd0, 8'h05, 8'h04, 0, 0, "t2_ack01_low");

    step(0, 0, 0, 8'h00, 1, 3'b011, 3'd2, 8'h01, 8'h01, 0, 0, "t3_speoi2");
    step(0, 0, 0, 8'h00, 1, 3'b110, 3'd3, 8'h01, 8'h01, 3, 0, "t3_setprio3");
    step(0, 0, 1, 8'h10, 0, 3'b000, 3'd0, 8'h11, 8'h10, 3, 0, "t3_ack10");

    step(0, 0, 0, 8'h00, 1, 3'b011, 3'd4, 8'h01, 8'h01, 3, 0, "t4_speoi4");
    step(0, 0, 0, 8'h00, 1, 3'b011, 3'd0, 8'h00, 8'h00, 3, 0, "t4_speoi0");
    step(0, 0, 1, 8'h08, 0, 3'b000, 3'd0, 8'h08, 8'h08, 3, 0, "t4_ack08");
    step(0, 0, 1, 8'h08, 1, 3'b001, 3'd0, 8'h08, 8'h08, 3, 0, "t4_ack_eoi_same");
    step(0, 0, 1, 8'h08, 0, 3'b000, 3'd0, 8'h08, 8'h08, 3, 1, "t4_reack_err");
    step(0, 0, 1, 8'h03, 0, 3'b000, 3'd0, 8'h0B, 8'h01, 3, 1, "t4_multihot");

    step(0, 0, 1, 8'hFF, 0, 3'b000, 3'd0, 8'hFF, 8'h10, 3, 1, "t5_fill");
    step(1, 0, 0, 8'h00, 1, 3'b101, 3'd0, 8'h00, 8'h00, 7, 0, "t5_reset_cmd");
    step(0, 0, 0, 8'h00, 1, 3'b101, 3'd0, 8'h00, 8'h00, 7, 0, "empty_rotns");
    step(0, 0, 0, 8'h00, 1, 3'b001, 3'd0, 8'h00, 8'h00, 7, 0, "empty_nseoi");
    step(0, 0, 1, 8'h20, 0, 3'b000, 3'd0, 8'h20, 8'h20, 7, 0, "ack20");
    step(0, 0, 0, 8'h00, 1, 3'b111, 3'd5, 8'h00, 8'h00, 5, 0, "rotsp5");
    step(0, 0, 0, 8'h00, 1, 3'b010, 3'd1, 8'h00, 8'h00, 5, 0, "nop");

    step(0, 1, 1, 8'h01, 0, 3'b000, 3'd0, 8'h01, 8'h01, 4, 0, "n5_ack01");
    step(0, 1, 1, 8'h10, 0, 3'b000, 3'd0, 8'h11, 8'h01, 4, 0, "n5_wrap");
    step(0, 1, 0, 8'h00, 1, 3'b011, 3'd6, 8'h11, 8'h01, 4, 0, "n5_lvl6_ignored");
    step(0, 1, 0, 8'h00, 1, 3'b110, 3'd7, 8'h11, 8'h01, 4, 0, "n5_lvl7_ignored");
    step(0, 1, 0, 8'h00, 1, 3'b101, 3'd0, 8'h10, 8'h10, 0, 0, "n5_rotns");
    step(0, 1, 0, 8'h00, 1, 3'b110, 3'd3, 8'h10, 8'h10, 3, 0, "n5_setprio3");
    step(0, 1, 1, 8'h01, 0, 3'b000, 3'd0, 8'h11, 8'h10, 3, 0, "n5_ack01");
    step(0, 1, 0, 8'h00, 1, 3'b111, 3'd4, 8'h01, 8'h01, 4, 0, "n5_rotsp4");

`ifdef IN_SERVICE_AEOI_EN
    a_aeoi = 1'b1;
    step(1, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h00, 7, 0, "a_reset");
    step(0, 0, 0, 8'h00, 1, 3'b100, 3'd0, 8'h00, 8'h00, 7, 0, "a_rotaeoi_on");
    step(0, 0, 1, 8'h20, 0, 3'b000, 3'd0, 8'h00, 8'h00, 5, 0, "a_ack20");
    step(0, 0, 0, 8'h00, 1, 3'b000, 3'd0, 8'h00, 8'h00, 5, 0, "a_rotaeoi_off");
    step(0, 0, 1, 8'h02, 0, 3'b000, 3'd0, 8'h00, 8'h00, 5, 0, "a_ack02");
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
